// File: rtl/reset_seq_pkg.sv
// Shared constants for the console reset sequencer: cause-vector layout and default timings.
// Latency: none (constants only).
// Backpressure: none (constants only).
package reset_seq_pkg;

    // The cause vector carries the generic sources in [NUM_SRC-1:0],
    // followed by two extra bits at these offsets above NUM_SRC.
    localparam int CAUSE_DL_OFS  = 0;
    localparam int CAUSE_DEF_OFS = 1;
    localparam int CAUSE_EXTRA   = 2;

    // Default timings: ~1000 clk_sys cycles of reset, and a deferred
    // reset roughly a tenth of a second after a ROM download ends.
    localparam int STRETCH_DEFAULT = 1000;
    localparam int DEFER_DEFAULT   = 5000000;
    localparam int CNT_W_DEFAULT   = 16;
    localparam int DEF_W_DEFAULT   = 23;

    // Width of the cause vector for a given number of generic sources.
    function automatic int cause_width(input int num_src);
        return num_src + CAUSE_EXTRA;
    endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Purpose: parametrised-width 2-flop synchronizer for asynchronous reset-request inputs (RESET_SEQ_SYNC_EN only).
// Latency: 2 clk_sys edges from input to output; outputs reset to 0 by reset_n.
// Backpressure: none; every bit is sampled every cycle.
`ifdef RESET_SEQ_SYNC_EN
module reset_seq_sync #(
    parameter int W = 1
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/reset_sequencer.sv
// Purpose: merges maskable reset requests, ROM download and a deferred post-download request into one stretched core_reset (optional input sync via RESET_SEQ_SYNC_EN).
// Latency: request sampled at edge k raises core_reset after edge k+2 (k+4 with RESET_SEQ_SYNC_EN); a 1-cycle request gives STRETCH cycles of reset.
// Backpressure: none; requests are levels, retriggers extend the pulse, pll_locked=0 forces core_reset high.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int STRETCH      = STRETCH_DEFAULT,
    parameter int DEFER_CYCLES = DEFER_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEF_W        = DEF_W_DEFAULT
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 pll_locked,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [NUM_SRC-1:0]   src_mask,
    input  logic                 download,
    input  logic                 defer_en,
    output logic                 core_reset,
    output logic                 defer_pending,
    output logic [NUM_SRC+1:0]   cause
);

    localparam int               CW         = cause_width(NUM_SRC);
    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH);
    localparam logic [DEF_W-1:0] DEFER_LD   = DEF_W'(DEFER_CYCLES);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] src_in;
    logic               download_in;
    logic               pll_in;

`ifdef RESET_SEQ_SYNC_EN
    logic [NUM_SRC+1:0] sync_d;
    logic [NUM_SRC+1:0] sync_q;

    assign sync_d = {pll_locked, download, src_req};

    // pll_locked synchronizes to 0 during reset, so core_reset stays
    // asserted until a real lock indication has crossed into clk_sys.
    reset_seq_sync #(
        .W (NUM_SRC + 2)
    ) u_sync (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .d       (sync_d),
        .q       (sync_q)
    );

    assign src_in      = sync_q[NUM_SRC-1:0];
    assign download_in = sync_q[NUM_SRC];
    assign pll_in      = sync_q[NUM_SRC+1];
`else
    assign src_in      = src_req;
    assign download_in = download;
    assign pll_in      = pll_locked;
`endif

    // ------------------------------------------------------------------
    // Deferred-reset timer
    // ------------------------------------------------------------------
    logic [DEF_W-1:0] def_timer;
    logic [DEF_W-1:0] def_timer_nxt;
    logic             def_fire;

    // Fires exactly once, on the last count before the timer reaches zero.
    assign def_fire = (def_timer == DEF_W'(1));

    // Held at full delay while the download runs, so the delay counts from
    // its falling edge; once armed, clearing defer_en does not cancel it.
    always_comb begin
        def_timer_nxt = def_timer;
        if (download_in && defer_en) begin
            def_timer_nxt = DEFER_LD;
        end else if (def_timer != '0) begin
            def_timer_nxt = def_timer - DEF_W'(1);
        end
    end

    // Timer register; defer_pending is registered from the same next value
    // so it always equals (def_timer != 0).
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            def_timer     <= '0;
            defer_pending <= 1'b0;
        end else begin
            def_timer     <= def_timer_nxt;
            defer_pending <= (def_timer_nxt != '0);
        end
    end

    // ------------------------------------------------------------------
    // Request stage
    // ------------------------------------------------------------------
    logic [CW-1:0] src_c;
    logic [CW-1:0] src_q;
    logic          req_c;
    logic          req_q;

    // Build the per-source request vector in cause-bit layout.
    always_comb begin
        src_c                         = '0;
        src_c[NUM_SRC-1:0]            = src_in & ~src_mask;
        src_c[NUM_SRC + CAUSE_DL_OFS] = download_in;
        src_c[NUM_SRC + CAUSE_DEF_OFS]= def_fire;
        req_c                         = |src_c;
    end

    // Register the merged request and its source vector together so cause
    // capture lines up with the counter reload.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req_q <= 1'b0;
            src_q <= '0;
        end else begin
            req_q <= req_c;
            src_q <= src_c;
        end
    end

    // ------------------------------------------------------------------
    // Stretch counter and core_reset
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stretch_cnt;

    // Reload on any registered request, otherwise count down to zero and stop.
    // Starts loaded so the core sees a full-length power-on reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            stretch_cnt <= STRETCH_LD;
        end else if (req_q) begin
            stretch_cnt <= STRETCH_LD;
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - CNT_W'(1);
        end
    end

    // Registered reset output; an unlocked PLL overrides the counter.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            core_reset <= 1'b1;
        end else begin
            core_reset <= (stretch_cnt != '0) || !pll_in;
        end
    end

    // ------------------------------------------------------------------
    // Cause capture
    // ------------------------------------------------------------------
    // A request arriving with the counter idle starts a fresh record;
    // requests landing inside a running pulse accumulate into it.
    // The record is left untouched once the pulse ends.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cause <= '0;
        end else if (req_q) begin
            if (stretch_cnt == '0) begin
                cause <= src_q;
            end else begin
                cause <= cause | src_q;
            end
        end
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised console reset sequencer, instantiated in each core top level between the user_io/data_io/PLL status and the emulated machine's `reset` input.
- Merges NUM_SRC maskable reset requests plus a ROM-download request into one stretched, registered reset pulse.
- Also times a deferred second reset after a download ends (logo skip).
- Generalises the fixed 1000-cycle/one-shot logic with a configurable width, count and delay, a power-on hold, PLL-lock gating and cause capture.

Parameters:
- NUM_SRC, 4, number of generic reset request inputs (1..8).
- STRETCH, 1000, core_reset width in clk_sys cycles for a single-cycle request (>=2).
- DEFER_CYCLES, 5000000, delay from download falling edge to deferred reset request (>=2).
- CNT_W, 16, stretch counter width; must satisfy STRETCH < 2**CNT_W.
- DEF_W, 23, defer timer width; must satisfy DEFER_CYCLES < 2**DEF_W.

Ports:
- clk_sys, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset of the sequencer itself.
- pll_locked, in, 1, core_reset is forced high while 0.
- src_req, in, NUM_SRC, level reset requests (OSD reset, button, etc.).
- src_mask, in, NUM_SRC, 1 = corresponding src_req ignored.
- download, in, 1, ROM download active (level); is always a reset source.
- defer_en, in, 1, 1 = arm deferred reset after download (status "Skip Logo").
- core_reset, out, 1, active-high reset to the console core.
- defer_pending, out, 1, deferred timer running.
- cause, out, NUM_SRC+2, sticky sources of the most recent reset. Bits [NUM_SRC-1:0] are src, bit NUM_SRC is download, bit NUM_SRC+1 is deferred.

Behaviour:
- Reset (reset_n=0, async):
  - stretch counter = STRETCH, so core_reset is 1 immediately after release.
  - defer timer = 0, defer_pending = 0, cause = 0, req_q = 0.
- Request stage:
  - req_c = |(src_req & ~src_mask) | download | def_fire.
  - req_q <= req_c, registered each cycle.
- Stretch counter:
  - If req_q is high, counter <= STRETCH.
  - Else if counter != 0, counter decrements by 1.
  - core_reset <= (counter != 0) | ~pll_locked, registered.
  - Latency: a request sampled at edge k raises core_reset after edge k+2.
  - A 1-cycle request gives core_reset high for exactly STRETCH cycles.
  - A held request keeps core_reset high for its whole duration plus STRETCH cycles after req_q falls.
  - Retriggering mid-pulse reloads the counter and extends the pulse; there is no gap.
- Cause:
  - On the cycle req_q rises while counter==0, cause <= the new source vector.
  - While the counter is nonzero, new sources are OR-ed into cause.
  - cause holds after core_reset falls, until the next fresh reset.
  - Power-on reset leaves cause = 0.
- Defer timer:
  - If download & defer_en, timer <= DEFER_CYCLES; it is reloaded every cycle, so the delay counts from the falling edge of download.
  - Else if timer != 0, timer decrements.
  - def_fire = (timer == 1), a 1-cycle pulse.
  - defer_pending = (timer != 0), registered.
  - If defer_en drops while the timer runs, the timer continues; it is cancelled only by reset_n.
- Simultaneous events: def_fire concurrent with src_req merges into one reload; cause captures both bits.
- pll_locked=0: core_reset is forced high; counters still run. On lock, core_reset follows the counter from the next edge.
- Arithmetic: unsigned; counters never wrap, since decrement is gated by !=0.

Optional Feature:
- RESET_SEQ_SYNC_EN defined:
  - src_req, download and pll_locked pass through 2-flop synchronizers, reset to 0 by reset_n; pll_locked resets to 0, so core_reset stays high.
  - Request-to-core_reset latency becomes 4 edges; the defer delay is unchanged relative to the synchronized download.
- Undefined: inputs are assumed synchronous to clk_sys, with the latencies given above.

Decomposition:
- Package reset_seq_pkg:
  - localparams for cause bit offsets (CAUSE_DL_OFS = 0, CAUSE_DEF_OFS = 1, both relative to NUM_SRC).
  - Default STRETCH and DEFER_CYCLES constants.
- Sub-module reset_seq_sync: parametrised-width 2-flop synchronizer, instantiated only under RESET_SEQ_SYNC_EN.

Test Plan (bench parameters STRETCH=8, DEFER_CYCLES=20, NUM_SRC=4, sync undefined):
- Release reset_n with pll_locked=1 and no requests -> core_reset=1 for 8 cycles then 0; cause=0.
- src_req=4'b0010 for 1 cycle at edge 10 -> core_reset high on edges 12..19, low at 20; cause=6'b000010.
- src_mask=4'b0010 with src_req=4'b0010 -> core_reset stays 0; cause unchanged.
- src_req[0] pulse, then src_req[3] pulse 4 cycles later -> one continuous pulse ending 8 cycles after the second request; cause=6'b001001.
- download high 5 cycles with defer_en=1 -> reset during download+8. defer_pending is high for 20 cycles after download falls; the deferred pulse then gives core_reset high for 8 cycles and cause=6'b100000. With defer_en=0 -> no second pulse.
- Drop pll_locked for 3 cycles while idle -> core_reset high in the following 3 cycles, then 0; cause unchanged. Assert reset_n=0 mid-defer -> defer_pending=0 immediately and no deferred pulse.
